// File: rtl/cs_pkg.sv
// Shared definitions for the computational-system (CS) datapath.
// The CS stage and the output buffer take their parameter defaults from here.
package cs_pkg;

   localparam int unsigned CS_DW    = 10;
   localparam int unsigned CS_WIN   = 9;
   localparam int unsigned CS_DEPTH = 8;

   typedef logic [CS_DW-1:0] cs_y_t;

endpackage

// File: rtl/cs_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is read combinationally.
// Reads return zero while the FIFO is empty. The storage array has no reset.
module cs_sync_fifo
   import cs_pkg::*;
#(
   parameter int unsigned DW    = CS_DW,
   parameter int unsigned DEPTH = CS_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DW-1:0]            wdata,
   output logic [DW-1:0]            rdata,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          do_push, do_pop;

   assign full  = (level_q == LW'(DEPTH));
   assign empty = (level_q == '0);
   assign level = level_q;
   assign rdata = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop & ~empty & ~flush;
      do_push  = push & (~full | do_pop) & ~flush;
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      level_d  = level_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         level_d = level_q + LW'(do_push) - LW'(do_pop);
      end
   end

   // Storage keeps its contents across reset; only the pointers are cleared.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q <= mem_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/cs_out_buffer.sv
// Output stage of the CS datapath: drops results while the window fills, buffers
// the valid ones in a FWFT FIFO and hands them out over valid/ready.
module cs_out_buffer
   import cs_pkg::*;
#(
   parameter int unsigned DW     = CS_DW,
   parameter int unsigned DEPTH  = CS_DEPTH,
   parameter int unsigned WARMUP = CS_WIN
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DW-1:0]            y_in,
   input  logic                     y_strobe,
   input  logic                     flush,
   input  logic                     clr_ovf,
   output logic [DW-1:0]            out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     warm,
   output logic                     overflow
);

   localparam int unsigned CW = $clog2(WARMUP + 1);

   logic [CW-1:0] warm_cnt_q, warm_cnt_d;
   logic          warm_q, warm_d;
   logic          overflow_q, overflow_d;
   logic          push_req, push, pop, drop;
   logic          fifo_full, fifo_empty;

   cs_sync_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .wdata (y_in),
      .rdata (out_data),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign out_valid = ~fifo_empty;
   assign warm      = warm_q;
   assign overflow  = overflow_q;

   always_comb begin
      pop      = out_valid & out_ready & ~flush;
      push_req = y_strobe & warm_q & ~flush;
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      push     = push_req & (~fifo_full | pop);
      drop     = push_req & fifo_full & ~pop;

      warm_cnt_d = warm_cnt_q;
      if (flush) begin
         warm_cnt_d = '0;
      end else if (y_strobe && !warm_q && (warm_cnt_q != CW'(WARMUP - 1))) begin
         warm_cnt_d = warm_cnt_q + CW'(1);
      end
      // Derived from the next count so the strobe right after the window fills is pushed.
      warm_d = (warm_cnt_d == CW'(WARMUP - 1));

      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
      end else if (clr_ovf && !flush) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         warm_cnt_q <= '0;
         warm_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         warm_cnt_q <= warm_cnt_d;
         warm_q     <= warm_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_cs_out_buffer.sv
// Bench for cs_out_buffer: directed scenarios then random traffic, all checked
// against a queue-based reference model.
module tb_cs_out_buffer;

   localparam int unsigned DW     = 10;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned WARMUP = 9;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [DW-1:0]           y_in;
   logic                    y_strobe;
   logic                    flush;
   logic                    clr_ovf;
   logic [DW-1:0]           out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [$clog2(DEPTH):0]  fifo_level;
   logic                    warm;
   logic                    overflow;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   logic [DW-1:0] m_q[$];
   int            m_strobes;
   bit            m_ovf;

   cs_out_buffer #(
      .DW     (DW),
      .DEPTH  (DEPTH),
      .WARMUP (WARMUP)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .y_in       (y_in),
      .y_strobe   (y_strobe),
      .flush      (flush),
      .clr_ovf    (clr_ovf),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .fifo_level (fifo_level),
      .warm       (warm),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit rst, input bit fl, input bit stb, input logic [DW-1:0] y,
                             input bit rdy, input bit clr);
      bit accept, pop_now, drop_now;
      if (rst) begin
         m_q.delete();
         m_strobes = 0;
         m_ovf     = 1'b0;
      end else if (fl) begin
         m_q.delete();
         m_strobes = 0;
      end else begin
         accept   = stb && (m_strobes >= WARMUP - 1);
         pop_now  = (m_q.size() > 0) && rdy;
         drop_now = accept && (m_q.size() == DEPTH) && !pop_now;
         if (stb) m_strobes++;
         if (pop_now) void'(m_q.pop_front());
         if (accept && !drop_now) m_q.push_back(y);
         if (drop_now) m_ovf = 1'b1;
         else if (clr) m_ovf = 1'b0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, 32'(out_valid), 32'(m_q.size() > 0));
      chk({tag, ".data"}, 32'(out_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
      chk({tag, ".level"}, 32'(fifo_level), 32'(m_q.size()));
      chk({tag, ".warm"}, 32'(warm), 32'(m_strobes >= WARMUP - 1));
      chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
   endtask

   // One clock: drive, clock, update model, check #1 after the edge.
   task automatic step(input string tag, input bit rst, input bit fl, input bit stb,
                       input logic [DW-1:0] y, input bit rdy, input bit clr);
      reset     = ~rst;
      flush     = fl;
      y_strobe  = stb;
      y_in      = y;
      out_ready = rdy;
      clr_ovf   = clr;
      @(posedge clk);
      model_edge(rst, fl, stb, y, rdy, clr);
      #1;
      check_all(tag);
   endtask

   initial begin
      m_strobes = 0;
      m_ovf     = 1'b0;
      // Reset
      step("rst", 1, 0, 0, 0, 0, 0);
      step("rst", 1, 0, 1, 10'd5, 1, 0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);

      // Warm-up: 12 strobes 100..111, first 8 discarded
      for (int i = 0; i < 12; i++) begin
         step("warmup", 0, 0, 1, 10'(100 + i), 0, 0);
         if (i == 6) chk("warm_before_8th", 32'(warm), 32'd0);
         if (i == 7) chk("warm_after_8th", 32'(warm), 32'd1);
      end
      for (int i = 0; i < 4; i++) begin
         chk("warmup_seq", 32'(out_data), 32'(108 + i));
         step("wu_drain", 0, 0, 0, 0, 1, 0);
      end

      // Backpressure: 10 strobes 1..10 into empty FIFO
      for (int i = 1; i <= 10; i++) begin
         step("bp_fill", 0, 0, 1, 10'(i), 0, 0);
         if (i == 8) chk("bp_no_ovf_8", 32'(overflow), 32'd0);
         if (i == 9) chk("bp_ovf_9", 32'(overflow), 32'd1);
      end
      chk("bp_level", 32'(fifo_level), 32'd8);
      for (int i = 1; i <= 8; i++) begin
         chk("bp_drain_seq", 32'(out_data), 32'(i));
         step("bp_drain", 0, 0, 0, 0, 1, 0);
      end
      chk("bp_empty", 32'(out_valid), 32'd0);

      // Simultaneous push/pop at full
      step("clr", 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 8; i++) step("full_fill", 0, 0, 1, 10'(20 + i), 0, 0);
      step("pp_full", 0, 0, 1, 10'd99, 1, 0);
      chk("pp_level", 32'(fifo_level), 32'd8);
      chk("pp_ovf", 32'(overflow), 32'd0);
      chk("pp_head", 32'(out_data), 32'd21);

      // Overflow: set wins over clear, then clear alone
      step("ovf_both", 0, 0, 1, 10'd500, 0, 1);
      chk("ovf_set_wins", 32'(overflow), 32'd1);
      step("ovf_clr", 0, 0, 0, 0, 0, 1);
      chk("ovf_cleared", 32'(overflow), 32'd0);

      // Flush mid-stream with level 5 and overflow set
      step("drop", 0, 0, 1, 10'd501, 0, 0);
      for (int i = 0; i < 3; i++) step("to5", 0, 0, 0, 0, 1, 0);
      chk("flush_pre_level", 32'(fifo_level), 32'd5);
      step("flush", 0, 1, 1, 10'd777, 1, 0);
      chk("flush_level", 32'(fifo_level), 32'd0);
      chk("flush_warm", 32'(warm), 32'd0);
      chk("flush_ovf", 32'(overflow), 32'd1);
      for (int i = 0; i < 8; i++) step("post_flush", 0, 0, 1, 10'(200 + i), 0, 0);
      chk("post_flush_level", 32'(fifo_level), 32'd0);
      for (int i = 0; i < 3; i++) step("refill", 0, 0, 1, 10'(300 + i), 0, 0);
      chk("refill_head", 32'(out_data), 32'd300);

      // Reset mid-operation
      step("rst_mid", 1, 0, 1, 10'd400, 1, 0);
      chk("rst_mid_level", 32'(fifo_level), 32'd0);
      chk("rst_mid_ovf", 32'(overflow), 32'd0);
      chk("rst_mid_data", 32'(out_data), 32'd0);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         step("rand",
              ($urandom_range(0, 299) == 0),
              ($urandom_range(0, 79) == 0),
              ($urandom_range(0, 99) < 60),
              10'($urandom),
              ($urandom_range(0, 99) < 45),
              ($urandom_range(0, 9) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
